// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_multiplier_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/seq_multiplier_ripple.sv
// ripple_adder_w: plain WIDTH-bit ripple-carry adder, one full adder per bit.
module ripple_adder_w #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic c;

   always_comb begin
      c   = cin;
      sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = x[i] ^ y[i] ^ c;
         c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per cycle.
// Option: SEQ_MULTIPLIER_EARLY_EXIT_EN finishes once remaining multiplier bits are 0.
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   state_t             state;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   sum;
   logic               cout;
   logic [2*WIDTH-1:0] step;
   logic [2*WIDTH-1:0] nxt;
   logic               last;
   logic               fin;

   assign addend = acc[0] ? mcand : '0;

   ripple_adder_w #(
      .WIDTH(WIDTH)
   ) u_add (
      .x   (acc[2*WIDTH-1:WIDTH]),
      .y   (addend),
      .cin (1'b0),
      .sum (sum),
      .cout(cout)
   );

   assign step = {cout, sum, acc[WIDTH-1:1]};
   assign last = (cnt == CW'(WIDTH - 1));

`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
   // Unconsumed multiplier bits sit in step[rem-1:0]; if all zero, the
   // remaining steps would only shift, so apply that shift at once.
   logic [CW-1:0]    rem;
   logic [WIDTH-1:0] mask;
   logic             early;

   assign rem   = CW'(WIDTH - 1) - cnt;
   assign mask  = ~({WIDTH{1'b1}} << rem);
   assign early = (step[WIDTH-1:0] & mask) == '0;
   assign nxt   = step >> rem;
   assign fin   = last | early;
`else
   assign nxt = step;
   assign fin = last;
`endif

   assign product = acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         mcand     <= '0;
         acc       <= '0;
         cnt       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand    <= a;
                  acc      <= {{WIDTH{1'b0}}, b};
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               acc <= nxt;
               if (!last) cnt <= cnt + 1'b1;
               if (fin) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH=32.
// Latency expectations follow SEQ_MULTIPLIER_EARLY_EXIT_EN when defined.
module tb_seq_multiplier;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] product;

   int checks;
   int errors;

   seq_multiplier #(
      .WIDTH(32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .product  (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the DUT in IDLE; returns at the negedge
   // where out_valid is first seen (or the bound expires).
   task automatic op(input logic [31:0] ta, input logic [31:0] tb_,
                     input logic [63:0] pexp, input int lfull,
                     input int lerly, input bit noise);
      int lat;
      int lexp;
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
      lexp = lerly;
`else
      lexp = lfull;
`endif
      a = ta;
      b = tb_;
      in_valid = 1'b1;
      chk("rdy_pre", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      chk("rdy_busy", in_ready, 0);
      while (!out_valid && lat < 100) begin
         if (noise) begin
            in_valid = ~in_valid;
            a = ~ta;
            b = 32'hFFFF_FFFF;
         end
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      chk("latency", lat, lexp);
      chk("product", product, pexp);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;

      repeat (2) @(negedge clk);
      chk("rst_rdy", in_ready, 1);
      chk("rst_vld", out_valid, 0);
      chk("rst_prod", product, 0);
      rst = 1'b0;

      @(negedge clk);
      op(32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 33, 17, 0);
      @(negedge clk);
      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 33, 0);
      @(negedge clk);
      op(32'd7, 32'd3, 64'd21, 33, 3, 0);
      @(negedge clk);
      op(32'hFFFF_FFFF, 32'd0, 64'd0, 33, 2, 0);
      @(negedge clk);
      op(32'd0, 32'hFFFF_FFFF, 64'd0, 33, 33, 0);
      @(negedge clk);
      op(32'd1, 32'h8000_0000, 64'h0000_0000_8000_0000, 33, 33, 0);

      // operand changes and in_valid toggles while busy must be ignored
      @(negedge clk);
      op(32'h0000_00FF, 32'h0000_0101, 64'h0000_0000_0000_FFFF, 33, 10, 1);

      // consumer stall in DONE
      @(negedge clk);
      out_ready = 1'b0;
      op(32'h8000_0000, 32'h8000_0001, 64'h4000_0000_8000_0000, 33, 33, 0);
      repeat (10) begin
         @(negedge clk);
         chk("hold_vld", out_valid, 1);
         chk("hold_prod", product, 64'h4000_0000_8000_0000);
         chk("hold_rdy", in_ready, 0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a = 32'd3;
      b = 32'd5;
      @(negedge clk);
      in_valid = 1'b0;
      chk("ret_rdy", in_ready, 1);
      chk("ret_vld", out_valid, 0);

      // reset after 12 busy steps
      @(negedge clk);
      a = 32'h1234_5678;
      b = 32'hFFFF_FFFF;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (12) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rdy", in_ready, 1);
      chk("mid_vld", out_valid, 0);
      chk("mid_prod", product, 0);
      @(negedge clk);
      rst = 1'b0;
      begin
         bit seen;
         seen = 1'b0;
         repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
         end
         chk("post_rst_vld", seen, 0);
      end
      chk("post_rst_rdy", in_ready, 1);

      // operand presented right at reset release is taken on the first edge
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      op(32'd6, 32'd7, 64'd42, 33, 4, 0);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; legal values are 8 to 64 in multiples of 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 The block SHALL have port a, input, WIDTH bits: the multiplicand, unsigned.
REQ-007 The block SHALL have port b, input, WIDTH bits: the multiplier, unsigned.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the product is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the product.
REQ-010 The block SHALL have port product, output, 2*WIDTH bits: the unsigned product a*b.

Function
REQ-011 The FSM SHALL have exactly three states, IDLE, BUSY and DONE, and SHALL enter IDLE on reset.
REQ-012 In IDLE, in_ready SHALL be 1; when in_valid is 1 in IDLE, the block SHALL capture a into a multiplicand register, load b into the low half of a 2*WIDTH accumulator, clear the high half, clear the iteration counter, and move to BUSY.
REQ-013 Outside IDLE, in_ready SHALL be 0, and in_valid and the operand inputs SHALL be ignored.
REQ-014 Each BUSY cycle SHALL perform one step:
- when accumulator bit 0 is 1, add the multiplicand to the high half, keeping carry-out as bit WIDTH of a (WIDTH+1)-bit sum;
- then shift {carry, high, low} right by one;
- then increment the counter.
REQ-015 The addition SHALL be performed by one combinational WIDTH-bit ripple adder with carry-in tied to 0; no other adder or multiplier SHALL be inferred for the datapath.
REQ-016 When the counter reaches WIDTH-1 and that step completes, the FSM SHALL move to DONE; the base latency from input acceptance to out_valid is therefore WIDTH+1 cycles.
REQ-017 In DONE, out_valid SHALL be 1 and product SHALL equal the accumulator, held stable while out_ready is 0.
REQ-018 In DONE with out_ready 1, the FSM SHALL return to IDLE on the next edge; a new operand pair SHALL NOT be accepted in that same cycle.
REQ-019 The counter SHALL be clog2(WIDTH) bits wide and SHALL NOT wrap within one operation.
REQ-020 Operands 0 SHALL produce product 0, and the all-ones case SHALL produce the full 2*WIDTH-bit result with no truncation.

Reset
REQ-021 Asserting rst SHALL immediately force state IDLE, in_ready 1, out_valid 0, product 0, and the counter and all registers 0.
REQ-022 Reset asserted mid-BUSY or in DONE SHALL discard the operation, and no out_valid SHALL follow reset release.
REQ-023 The first operand pair SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-024 Macro SEQ_MULTIPLIER_EARLY_EXIT_EN SHALL be the only compile-time option.
REQ-025 When SEQ_MULTIPLIER_EARLY_EXIT_EN is defined:
- if the not-yet-consumed multiplier bits are all 0 after a step, the FSM SHALL go to DONE at that edge;
- the accumulator SHALL be right-shifted by the remaining iteration count in the same edge, so product is identical to the full run;
- b=0 SHALL complete in 1 BUSY cycle.
REQ-026 When the macro is undefined, every operation SHALL take exactly WIDTH BUSY cycles, and no early-exit logic SHALL be present.

Structure
REQ-027 Package seq_multiplier_pkg SHALL hold the state enum type (IDLE, BUSY, DONE) and the default-width constant.
REQ-028 The adder SHALL be a single sub-module, ripple_adder_w, parameterised by WIDTH, with ports x, y, cin, sum and cout.
REQ-029 The top level SHALL contain only the FSM, the counter, the registers and the handshake logic.

Verification
REQ-030 Bench SHALL drive a=0x0000FFFF, b=0x0000FFFF, out_ready=1 and check product=0x00000000FFFE0001 with out_valid 33 cycles after acceptance (macro undefined).
REQ-031 Bench SHALL drive a=0xFFFFFFFF, b=0xFFFFFFFF and check product=0xFFFFFFFE00000001.
REQ-032 Bench SHALL hold out_ready=0 for 10 cycles in DONE and check that product and out_valid stay stable and in_ready stays 0; it SHALL then pulse out_ready and check IDLE on the next cycle.
REQ-033 Bench SHALL pulse rst during BUSY at iteration 12 and check that all outputs read 0 and in_ready reads 1 immediately, with no out_valid afterwards.
REQ-034 Bench SHALL toggle in_valid with new operands during BUSY and check that the result matches only the originally accepted pair.
REQ-035 With SEQ_MULTIPLIER_EARLY_EXIT_EN defined, bench SHALL drive a=7, b=3 and check product=21 with out_valid 3 cycles after acceptance; it SHALL drive b=0 and check product=0 after 2 cycles.
